// File: rtl/csc_pkg.sv
// Shared definitions for the CSC weight encoder: field widths, the
// terminator word, the {data, count} word packer and the FSM states.
package csc_pkg;

  localparam int CSC_DATA_W = 8;
  localparam int CSC_CNT_W  = 4;
  localparam int CSC_WORD_W = 12;

  // All-zero word that closes a spad write. A real entry always has a
  // nonzero weight field, so it can never look like this word.
  localparam logic [CSC_WORD_W-1:0] CSC_TERM_WORD = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_TERM   = 2'd2,
    ST_DONE   = 2'd3
  } csc_state_e;

  // Pack one data spad entry: weight in the upper bits, row index below.
  function automatic logic [CSC_WORD_W-1:0] csc_pack(
    input logic [CSC_DATA_W-1:0] data,
    input logic [CSC_CNT_W-1:0]  count
  );
    return {data, count};
  endfunction

endpackage

// File: rtl/csc_out_slot.sv
// One-entry registered output slot with a valid/ready port.
//
// Handshake: a word transfers on a cycle where o_valid and i_ready are both
// high. While o_valid is high and i_ready is low, o_data is held stable.
// o_free tells the producer that a new word may be loaded this cycle: the
// slot is empty, or its current word is transferring now. The producer
// must only raise i_load while o_free is high.
module csc_out_slot #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_free
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Load takes priority over drain so back-to-back words flow at full rate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/csc_weight_encoder.sv
// Streaming CSC encoder feeding the PE weight spads. Dense column-major
// INT8 weights come in; nonzero weights leave as {weight, row} words for
// the data spad, followed by one all-zero terminator, and each column
// produces its exclusive end pointer for the address spad.
//
// Handshake (every port pair here): a transfer happens on a cycle where
// valid and ready are both high; a producer holds valid and payload
// stable until that cycle, and valid never depends on ready.
module csc_weight_encoder
  import csc_pkg::*;
#(
  parameter int SPAD_DEPTH = 108,
  parameter int ADDR_W     = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CSC_CNT_W-1:0]  cfg_rows,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CSC_DATA_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [CSC_WORD_W-1:0] data_out,
  output logic                  data_write_en,
  output logic                  addr_out_valid,
  input  logic                  addr_out_ready,
  output logic [ADDR_W-1:0]     addr_out,
  output logic                  done,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  // Last usable data word; the final spad entry is kept for the terminator.
  localparam logic [ADDR_W-1:0] NZ_MAX = ADDR_W'(SPAD_DEPTH - 1);

  csc_state_e r_state;
  csc_state_e w_state_nxt;

  logic [CSC_CNT_W-1:0]  r_row_cnt;
  logic [CSC_CNT_W-1:0]  r_cfg_rows;
  logic [ADDR_W-1:0]     r_nz_cnt;
  logic                  r_overflow;

  logic                  w_data_free;
  logic                  w_addr_free;
  logic                  w_data_valid;
  logic                  w_addr_valid;
  logic [CSC_WORD_W-1:0] w_data_q;
  logic [ADDR_W-1:0]     w_addr_q;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_nonzero;
  logic                  w_room;
  logic                  w_wr_word;
  logic                  w_drop;
  logic                  w_col_end;
  logic [ADDR_W-1:0]     w_nz_next;
  logic                  w_term_load;
  logic                  w_data_load;
  logic [CSC_WORD_W-1:0] w_data_word;
  logic                  w_done;

  // Input is taken only while encoding and when both output slots can
  // absorb whatever this element produces.
  assign w_in_ready = (r_state == ST_ENCODE) && w_data_free && w_addr_free;
  assign w_accept   = in_valid && w_in_ready;
  assign w_nonzero  = |in_data;
  assign w_room     = r_nz_cnt < NZ_MAX;
  assign w_wr_word  = w_accept && w_nonzero && w_room;
  assign w_drop     = w_accept && w_nonzero && !w_room;
  assign w_col_end  = w_accept && ((r_row_cnt == r_cfg_rows) || in_last);

  // The column-end pointer includes the current element when it was written.
  assign w_nz_next  = w_wr_word ? (r_nz_cnt + ADDR_W'(1)) : r_nz_cnt;

  // Terminator goes in once the data slot is empty or draining its last word.
  assign w_term_load = (r_state == ST_TERM) && w_data_free;
  assign w_data_load = w_wr_word || w_term_load;
  assign w_data_word = w_term_load ? CSC_TERM_WORD : csc_pack(in_data, r_row_cnt);

  assign w_done = (r_state == ST_DONE) && w_data_valid && data_out_ready;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for one matrix: encode, emit terminator, wait for it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start)                w_state_nxt = ST_ENCODE;
      ST_ENCODE: if (w_accept && in_last)  w_state_nxt = ST_TERM;
      ST_TERM:   if (w_term_load)          w_state_nxt = ST_DONE;
      ST_DONE:   if (w_done)               w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // Row / nonzero counters, latched geometry and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row_cnt  <= '0;
      r_cfg_rows <= '0;
      r_nz_cnt   <= '0;
      r_overflow <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_row_cnt  <= '0;
      r_cfg_rows <= cfg_rows;
      r_nz_cnt   <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if ((r_row_cnt == r_cfg_rows) || in_last) begin
        r_row_cnt <= '0;
      end else begin
        r_row_cnt <= r_row_cnt + CSC_CNT_W'(1);
      end
      if (w_wr_word) begin
        r_nz_cnt <= w_nz_next;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  csc_out_slot #(.W(CSC_WORD_W)) u_data_slot (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_data_load),
    .i_data  (w_data_word),
    .i_ready (data_out_ready),
    .o_valid (w_data_valid),
    .o_data  (w_data_q),
    .o_free  (w_data_free)
  );

  csc_out_slot #(.W(ADDR_W)) u_addr_slot (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_col_end),
    .i_data  (w_nz_next),
    .i_ready (addr_out_ready),
    .o_valid (w_addr_valid),
    .o_data  (w_addr_q),
    .o_free  (w_addr_free)
  );

  assign in_ready       = w_in_ready;
  assign data_out_valid = w_data_valid;
  assign data_write_en  = w_data_valid;
  assign data_out       = w_data_q;
  assign addr_out_valid = w_addr_valid;
  assign addr_out       = w_addr_q;
  assign done           = w_done;
  assign overflow       = r_overflow;
  assign dbg_state      = r_state;

endmodule

// File: doc/csc_weight_encoder.md
# csc_weight_encoder

Streaming compressed-sparse-column (CSC) encoder on the write side of the PE weight data scratchpad. It accepts dense INT8 weights in column-major order and emits the 12-bit `{data, count}` word stream consumed by the weight data spad, including the all-zero terminator word that ends a spad write. In parallel it emits one column-end address per column for the weight address spad. It sits between the GLB weight router port and the PE spads.

## Interface

Parameters
- `SPAD_DEPTH`, 108: data spad capacity in words, including the terminator.
- `ADDR_W`, 7: address and pointer width.

Ports
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin one matrix. Sampled only in IDLE.
- `cfg_rows` in 4: rows per column minus 1 (0..15). Latched at `start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 8, `in_last` in 1: dense weight stream. `in_last` marks the final element of the matrix.
- `data_out_valid` out 1, `data_out_ready` in 1, `data_out` out 12: `[11:4]` = weight, `[3:0]` = row index (count).
- `data_write_en` out 1: equals `data_out_valid`. Drives the spad `write_en`.
- `addr_out_valid` out 1, `addr_out_ready` in 1, `addr_out` out 7: exclusive end pointer of the column just finished.
- `done` out 1: one-cycle pulse when the terminator handshakes.
- `overflow` out 1: sticky; cleared on `start`.

## Operation

- FSM states are IDLE, ENCODE, TERM and DONE.
  - IDLE → ENCODE on `start`. This clears `row_cnt`, `nz_cnt` and `overflow`, and latches `cfg_rows`.
  - ENCODE → TERM when an `in_last` element handshakes.
  - TERM → DONE when the terminator word is loaded into the data output register.
  - DONE → IDLE when the terminator handshakes. `done` pulses in that same cycle.
- Input handshake is `in_valid & in_ready`.
  - `in_ready = (state==ENCODE) & data slot free-or-draining & addr slot free-or-draining`.
  - "Free-or-draining" means the slot's valid is low, or its valid and ready are both high.
- For each accepted element:
  - If `in_data != 0` and `nz_cnt < SPAD_DEPTH-1`, load `{in_data, row_cnt}` into the data slot and increment `nz_cnt`.
  - If `in_data != 0` and `nz_cnt == SPAD_DEPTH-1`, drop the word and set `overflow`.
  - Zero weights produce no data word.
- `row_cnt` increments per accepted element and wraps to 0 after reaching `cfg_rows`. On that wrap, or on `in_last`, load `nz_cnt` into the address slot. The loaded value includes the current element if that element was written.
- Empty columns emit an address equal to the previous one.
- `in_last` forces a column end even if `row_cnt != cfg_rows`. `row_cnt` is then reset.
- Terminator: `data_out = 12'h000`, emitted exactly once per matrix. It is not counted in `nz_cnt` and is always emitted, even after overflow.
- A nonzero weight at row 0 encodes nonzero (the weight field is nonzero), so it is never confused with the terminator.
- `nz_cnt` is 7 bits and saturates at `SPAD_DEPTH-1`. It never wraps.

## Timing

- Reset values: `in_ready`=0, `data_out_valid`=0, `data_write_en`=0, `data_out`=0, `addr_out_valid`=0, `addr_out`=0, `done`=0, `overflow`=0. State is IDLE.
- Both outputs are registered, single-entry slots.
  - Latency is 1 cycle from input handshake to `*_valid`.
  - Throughput is 1 element/cycle while both readies are held high.
- A valid output holds its value stable until ready is seen.
- The terminator word is valid no earlier than the cycle after `in_last` is accepted, and no earlier than the cycle after the last data word handshakes.
- `start` outside IDLE is ignored.
- Reset asserted mid-matrix aborts immediately. No terminator is emitted and all outputs go to their reset values.

## Structure

- Shared package `csc_pkg` holds:
  - `CSC_DATA_W`=8, `CSC_CNT_W`=4, `CSC_WORD_W`=12.
  - `CSC_TERM_WORD`=12'h000.
  - The word-pack function `{data, count}`.
  - The FSM state enum.
- Sub-module `csc_out_slot`: a one-entry valid/ready register, parameterised on width. Instantiated twice (data slot, address slot).

## Test plan

- `cfg_rows`=3, one column `[0,5,0,-2]` + `in_last`:
  - data `{8'h05,4'd1}`, `{8'hFE,4'd3}`, `12'h000`;
  - addr 2;
  - `done` pulses once.
- `cfg_rows`=1, input `[0,0, 7,0, 0,0]` with `in_last` on the final element:
  - addr sequence 0, 1, 1;
  - single data word `{8'h07,4'd0}` then terminator.
- 16-row all-nonzero column, `data_out_ready` toggled 1/0 every cycle:
  - 16 words with counts 0..15, each held stable while not ready;
  - addr 16.
- 120 nonzero weights, `cfg_rows`=15:
  - exactly 107 data words;
  - `overflow`=1 at element 108;
  - terminator still emitted;
  - final addr 107.
- Reset deasserted→asserted in the middle of the second column:
  - all outputs 0 the same cycle, state IDLE;
  - a new `start` encodes correctly from pointer 0.
- `start` pulsed during ENCODE:
  - ignored; counters and `cfg_rows` unchanged.
